// File: rtl/glb_core_bank_rdrq_arb.sv
// Per-bank round-robin read-request arbiter with a tag pipeline that routes bank read data back to its requester.
// Latency: grant comb in N, bank strobe in N+1, response in N+1+RD_LATENCY; clk_en low stalls everything and holds req_ready low.
// Backpressure: req_valid/req_ready handshake per requester; GLB_RDRQ_ARB_PROC_PRIORITY_EN gives requester 0 strict priority.
module glb_core_bank_rdrq_arb #(
  parameter int NUM_REQ      = 4,
  parameter int NUM_BANKS    = 2,
  parameter int ADDR_WIDTH   = 17,
  parameter int BANK_SEL_BIT = 16,
  parameter int DATA_WIDTH   = 64,
  parameter int RD_LATENCY   = 2
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic                                      clk_en,
  input  logic [NUM_REQ-1:0]                        req_valid,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]        req_addr,
  output logic [NUM_REQ-1:0]                        req_ready,
  output logic [NUM_BANKS-1:0]                      bank_rd_en,
  output logic [NUM_BANKS-1:0][BANK_SEL_BIT-1:0]    bank_rd_addr,
  input  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]      bank_rd_data,
  output logic [NUM_REQ-1:0]                        rsp_valid,
  output logic [NUM_REQ-1:0][DATA_WIDTH-1:0]        rsp_data
);

  localparam int IDW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DEPTH = RD_LATENCY + 1;
  localparam logic [IDW:0] NREQ = (IDW+1)'(NUM_REQ);

`ifdef GLB_RDRQ_ARB_PROC_PRIORITY_EN
  localparam bit PRIO0 = 1'b1;
  localparam logic [NUM_REQ-1:0] RR_MASK = {{(NUM_REQ-1){1'b1}}, 1'b0};
`else
  localparam bit PRIO0 = 1'b0;
  localparam logic [NUM_REQ-1:0] RR_MASK = {NUM_REQ{1'b1}};
`endif

  logic [NUM_BANKS-1:0][IDW-1:0]          rr_ptr;
  logic [NUM_BANKS-1:0][NUM_REQ-1:0]      elig;
  logic [NUM_BANKS-1:0]                   gnt_vld;
  logic [NUM_BANKS-1:0][IDW-1:0]          gnt_id;
  logic [NUM_BANKS-1:0][BANK_SEL_BIT-1:0] gnt_addr;
  logic [NUM_BANKS-1:0][DEPTH-1:0]        tag_vld;
  logic [NUM_BANKS-1:0][DEPTH-1:0][IDW-1:0] tag_id;

  function automatic logic [IDW-1:0] inc_wrap(input logic [IDW-1:0] v);
    logic [IDW:0] s;
    s = {1'b0, v} + (IDW+1)'(1);
    return (s >= NREQ) ? '0 : s[IDW-1:0];
  endfunction

  // Stalled or in-reset cycles see no eligible requesters, so no grant can form.
  always_comb begin
    elig = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        elig[b][k] = clk_en && reset_n && req_valid[k] &&
                     (32'(req_addr[k][BANK_SEL_BIT]) == b);
      end
    end
  end

  always_comb begin
    logic [IDW:0] idx;
    gnt_vld  = '0;
    gnt_id   = '0;
    gnt_addr = '0;
    idx      = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (PRIO0 && elig[b][0]) begin
        gnt_vld[b] = 1'b1;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        idx = {1'b0, rr_ptr[b]} + (IDW+1)'(i);
        if (idx >= NREQ) idx = idx - NREQ;
        if (!gnt_vld[b] && (elig[b][idx[IDW-1:0]] & RR_MASK[idx[IDW-1:0]])) begin
          gnt_vld[b] = 1'b1;
          gnt_id[b]  = idx[IDW-1:0];
        end
      end
      gnt_addr[b] = req_addr[gnt_id[b]][BANK_SEL_BIT-1:0];
    end
  end

  always_comb begin
    req_ready = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (gnt_vld[b]) req_ready[gnt_id[b]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr       <= '0;
      bank_rd_en   <= '0;
      bank_rd_addr <= '0;
      tag_vld      <= '0;
      tag_id       <= '0;
    end else if (clk_en) begin
      bank_rd_en <= gnt_vld;
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (gnt_vld[b]) begin
          bank_rd_addr[b] <= gnt_addr[b];
          // A strict-priority requester-0 grant leaves the round-robin order untouched.
          if (!PRIO0 || (gnt_id[b] != '0)) rr_ptr[b] <= inc_wrap(gnt_id[b]);
        end
        tag_vld[b][0] <= gnt_vld[b];
        tag_id[b][0]  <= gnt_id[b];
        for (int s = 1; s < DEPTH; s++) begin
          tag_vld[b][s] <= tag_vld[b][s-1];
          tag_id[b][s]  <= tag_id[b][s-1];
        end
      end
    end
  end

  // A response held by a stall is presented once, on the enabled cycle that consumes it.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (clk_en && tag_vld[b][DEPTH-1]) begin
        rsp_valid[tag_id[b][DEPTH-1]] = 1'b1;
        rsp_data[tag_id[b][DEPTH-1]]  = bank_rd_data[b];
      end
    end
  end

endmodule

// File: tb/tb_glb_core_bank_rdrq_arb.sv
// Bench for glb_core_bank_rdrq_arb: directed scenarios plus randomized traffic against a queue-based model
// that schedules each response a fixed number of enabled cycles after its grant.
module tb_glb_core_bank_rdrq_arb;
  localparam int NR = 4, NB = 2, AW = 17, DW = 64, RDL = 2;
`ifdef GLB_RDRQ_ARB_PROC_PRIORITY_EN
  localparam bit PRIO = 1'b1;
  localparam logic [3:0] EXP_ORD [8] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
`else
  localparam bit PRIO = 1'b0;
  localparam logic [3:0] EXP_ORD [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    reset_n, clk_en;
  logic [NR-1:0]           req_valid;
  logic [NR-1:0][AW-1:0]   req_addr;
  logic [NR-1:0]           req_ready;
  logic [NB-1:0]           bank_rd_en;
  logic [NB-1:0][15:0]     bank_rd_addr;
  logic [NB-1:0][DW-1:0]   bank_rd_data;
  logic [NR-1:0]           rsp_valid;
  logic [NR-1:0][DW-1:0]   rsp_data;

  logic [NR-1:0]           req_ready1;
  logic [0:0]              bank_rd_en1;
  logic [0:0][15:0]        bank_rd_addr1;
  logic [0:0][DW-1:0]      bank_rd_data1;
  logic [NR-1:0]           rsp_valid1;
  logic [NR-1:0][DW-1:0]   rsp_data1;
  assign bank_rd_data1[0] = bank_rd_data[0];

  glb_core_bank_rdrq_arb u_dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .bank_rd_en(bank_rd_en), .bank_rd_addr(bank_rd_addr), .bank_rd_data(bank_rd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data)
  );

  glb_core_bank_rdrq_arb #(.NUM_BANKS(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready1),
    .bank_rd_en(bank_rd_en1), .bank_rd_addr(bank_rd_addr1), .bank_rd_data(bank_rd_data1),
    .rsp_valid(rsp_valid1), .rsp_data(rsp_data1)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Reference model: pointer per bank, list of scheduled responses keyed by enabled-cycle count.
  typedef struct { int k; int b; int due; } fl_t;
  fl_t         fl[$];
  int          rr_m [NB];
  int          ecnt;
  bit          last_en [NB];
  logic [15:0] last_addr [NB];

  function automatic int bank_of(input int k);
    return int'(req_addr[k][16]);
  endfunction

  always @(negedge clk) begin : cmp
    logic [NR-1:0]         e_rdy, e_rv;
    logic [NR-1:0][DW-1:0] e_rd;
    logic [NB-1:0]         e_en;
    logic [NB-1:0][15:0]   e_addr;
    int                    win [NB];
    if (!reset_n) begin
      check("rst_outputs", {req_ready, rsp_valid, bank_rd_en, bank_rd_addr}, '0);
      check("rst_rsp_data", rsp_data, '0);
      fl.delete();
      ecnt = 0;
      for (int b = 0; b < NB; b++) begin
        rr_m[b] = 0; last_en[b] = 1'b0; last_addr[b] = '0;
      end
    end else begin
      e_rdy = '0; e_rv = '0; e_rd = '0;
      for (int b = 0; b < NB; b++) begin
        win[b] = -1;
        if (clk_en) begin
          if (PRIO && req_valid[0] && bank_of(0) == b) win[b] = 0;
          for (int i = 0; i < NR; i++) begin
            int k;
            k = (rr_m[b] + i) % NR;
            if (win[b] < 0 && !(PRIO && k == 0) && req_valid[k] && bank_of(k) == b) win[b] = k;
          end
        end
        if (win[b] >= 0) e_rdy[win[b]] = 1'b1;
        e_en[b]   = last_en[b];
        e_addr[b] = last_addr[b];
      end
      if (clk_en) begin
        foreach (fl[i]) begin
          if (fl[i].due == ecnt) begin
            e_rv[fl[i].k] = 1'b1;
            e_rd[fl[i].k] = bank_rd_data[fl[i].b];
          end
        end
      end
      check("req_ready", req_ready, e_rdy);
      check("rsp_valid", rsp_valid, e_rv);
      check("rsp_data", rsp_data, e_rd);
      check("bank_rd_en", bank_rd_en, e_en);
      check("bank_rd_addr", bank_rd_addr, e_addr);
      if (clk_en) begin
        ecnt++;
        for (int b = 0; b < NB; b++) begin
          last_en[b] = (win[b] >= 0);
          if (win[b] >= 0) begin
            last_addr[b] = req_addr[win[b]][15:0];
            fl.push_back('{win[b], b, ecnt + RDL});
            if (!(PRIO && win[b] == 0)) rr_m[b] = (win[b] + 1) % NR;
          end
        end
        for (int i = fl.size() - 1; i >= 0; i--) begin
          if (fl[i].due < ecnt) fl.delete(i);
        end
      end
    end
  end

  logic [3:0] gseq [8];
  logic [3:0] rsp_hist [11];

  initial begin
    reset_n = 1'b0; clk_en = 1'b1; req_valid = '0; req_addr = '0; bank_rd_data = '0;
    repeat (3) next();

    // All four requesters on bank 0: rotation and fixed latency.
    reset_n = 1'b1;
    req_valid = 4'hF;
    for (int k = 0; k < NR; k++) req_addr[k] = 17'(k * 64);
    for (int t = 0; t < 11; t++) begin
      if (t == 8) req_valid = '0;
      @(negedge clk);
      if (t < 8) gseq[t] = req_ready;
      rsp_hist[t] = rsp_valid;
      next();
    end
    for (int t = 0; t < 3; t++) check("rr_rsp_early", rsp_hist[t], 4'h0);
    for (int t = 0; t < 8; t++) begin
      check("rr_order", gseq[t], EXP_ORD[t]);
      check("rr_rsp_lat", rsp_hist[t+3], EXP_ORD[t]);
    end

    // Two banks in parallel.
    bank_rd_data[0] = 64'hA0A0_A0A0_0000_0001;
    bank_rd_data[1] = 64'hB1B1_B1B1_0000_0002;
    req_valid = 4'b0101; req_addr[0] = 17'h00100; req_addr[2] = 17'h10200;
    @(negedge clk); check("dual_ready", req_ready, 4'b0101); next();
    req_valid = '0;
    @(negedge clk);
    check("dual_en", bank_rd_en, 2'b11);
    check("dual_addr0", bank_rd_addr[0], 16'h0100);
    check("dual_addr1", bank_rd_addr[1], 16'h0200);
    next();
    next();
    @(negedge clk);
    check("dual_rsp_valid", rsp_valid, 4'b0101);
    check("dual_rsp_data0", rsp_data[0], 64'hA0A0_A0A0_0000_0001);
    check("dual_rsp_data2", rsp_data[2], 64'hB1B1_B1B1_0000_0002);
    next();

    // Two stalled cycles while a read is in flight.
    req_valid = 4'b0010; req_addr[1] = 17'h00ABC;
    @(negedge clk); check("stall_grant", req_ready, 4'b0010); next();
    clk_en = 1'b0; req_valid = 4'b0001; req_addr[0] = 17'h00010;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      check("stall_no_grant", req_ready, 4'b0000);
      check("stall_no_rsp", rsp_valid, 4'b0000);
      next();
    end
    clk_en = 1'b1; req_valid = '0;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk); check("stall_rsp_wait", rsp_valid, 4'b0000); next();
    end
    @(negedge clk);
    check("stall_rsp_valid", rsp_valid, 4'b0010);
    check("stall_rsp_data", rsp_data[1], 64'hA0A0_A0A0_0000_0001);
    next();

    // Reset one cycle after a grant drops the response.
    req_valid = 4'b0100; req_addr[2] = 17'h10030;
    @(negedge clk); check("pre_rst_grant", req_ready, 4'b0100); next();
    reset_n = 1'b0; req_valid = 4'hF;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      check("in_rst_ready", req_ready, 4'b0000);
      check("in_rst_en", bank_rd_en, 2'b00);
      next();
    end
    reset_n = 1'b1; req_valid = '0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk); check("post_rst_no_rsp", rsp_valid, 4'b0000); next();
    end

    // Bank index beyond NUM_BANKS on the single-bank instance.
    req_valid = 4'b1000; req_addr[3] = 17'h10040;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      check("nobank_ready", req_ready1[3], 1'b0);
      check("nobank_en", bank_rd_en1, 1'b0);
      next();
    end
    req_valid = '0;
    next();

`ifdef GLB_RDRQ_ARB_PROC_PRIORITY_EN
    req_valid = 4'b0011; req_addr[0] = 17'h00008; req_addr[1] = 17'h00018;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk); check("prio_r0_wins", req_ready, 4'b0001); next();
    end
    req_valid = 4'b0010;
    @(negedge clk); check("prio_r1_after", req_ready, 4'b0010); next();
    req_valid = '0;
`endif

    // Randomized traffic, stalls and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      reset_n   = ($urandom_range(0, 299) != 0);
      clk_en    = ($urandom_range(0, 9) != 0);
      req_valid = 4'($urandom);
      for (int k = 0; k < NR; k++) req_addr[k] = 17'($urandom);
      bank_rd_data = {$urandom, $urandom, $urandom, $urandom};
      next();
    end
    reset_n = 1'b1; clk_en = 1'b1; req_valid = '0;
    repeat (8) next();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/glb_core_bank_rdrq_arb.md
GLB_CORE_BANK_RDRQ_ARB -- requirements
Module: glb_core_bank_rdrq_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: read requesters; index 0 proc router, 1 strm router, 2 load DMA, 3 pc DMA.
REQ-002 Parameter NUM_BANKS, default 2: banks per tile.
REQ-003 Parameter ADDR_WIDTH, default 17: tile-local byte address; bit BANK_SEL_BIT selects the bank.
REQ-004 Parameter BANK_SEL_BIT, default 16: address bit used for bank select.
REQ-005 Parameter DATA_WIDTH, default 64: read data width.
REQ-006 Parameter RD_LATENCY, default 2: cycles from bank_rd_en to bank_rd_data valid; minimum 1.
REQ-007 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-008 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-009 Port clk_en, input, 1: state-update enable.
REQ-010 Port req_valid, input, NUM_REQ: request pending per requester.
REQ-011 Port req_addr, input, NUM_REQ x ADDR_WIDTH: request address per requester.
REQ-012 Port req_ready, output, NUM_REQ: combinational grant; a request completes when req_valid and req_ready are both high.
REQ-013 Port bank_rd_en, output, NUM_BANKS: registered bank read strobe.
REQ-014 Port bank_rd_addr, output, NUM_BANKS x BANK_SEL_BIT: registered bank-local address (req_addr[BANK_SEL_BIT-1:0]).
REQ-015 Port bank_rd_data, input, NUM_BANKS x DATA_WIDTH: bank read data.
REQ-016 Port rsp_valid, output, NUM_REQ: response strobe per requester.
REQ-017 Port rsp_data, output, NUM_REQ x DATA_WIDTH: response data, zero when rsp_valid is low.

Function
REQ-018 Each bank has an independent round-robin arbiter over the requesters whose req_valid is high and whose req_addr[BANK_SEL_BIT] selects that bank.
REQ-019 Each arbiter grants at most one requester per cycle; the search starts at rr_ptr[b] and ascends with wrap-around.
REQ-020 On a grant to requester k at bank b with clk_en high, rr_ptr[b] becomes (k+1) mod NUM_REQ; with no grant, rr_ptr[b] holds.
REQ-021 A requester targets exactly one bank per cycle, so it receives at most one grant per cycle.
REQ-022 req_ready is forced low for all requesters while clk_en is low.
REQ-023 A grant in cycle N drives bank_rd_en[b] high and bank_rd_addr[b] with the granted address in cycle N+1; with no grant, bank_rd_en[b] is low in N+1 and bank_rd_addr[b] holds.
REQ-024 Each bank has a tag pipeline of depth 1+RD_LATENCY that carries {valid, requester id}.
REQ-025 rsp_valid[k] is high in cycle N+1+RD_LATENCY, and rsp_data[k] then equals bank_rd_data[b] for that cycle (combinational pass-through).
REQ-026 All banks share one fixed latency, so no two banks return data to the same requester in the same cycle; no response collision logic exists.
REQ-027 Throughput per bank is one grant per cycle; back-to-back grants to the same requester are allowed when it is the only requester.
REQ-028 While clk_en is low, rr_ptr, the bank outputs and the tag pipelines all hold.
REQ-029 An address with BANK_SEL_BIT selecting a bank at or above NUM_BANKS is never granted; req_ready stays low for that requester.

Reset
REQ-030 On reset_n low, asynchronously: rr_ptr = 0 for every bank, bank_rd_en = 0, bank_rd_addr = 0, and all tag pipelines are cleared to invalid.
REQ-031 While reset_n is low, req_ready, rsp_valid and rsp_data are all 0.
REQ-032 Reset during in-flight reads drops those responses; no rsp_valid pulse occurs for any grant issued before reset deassertion.
REQ-033 The first grant is possible in the first clk edge with reset_n high.

Configuration
REQ-034 Macro GLB_RDRQ_ARB_PROC_PRIORITY_EN, when defined, gives requester 0 strict priority at every bank over all others.
REQ-035 With that macro, the remaining requesters round-robin among themselves, and rr_ptr does not advance on a requester-0 grant.
REQ-036 Without that macro, all requesters share pure round-robin as in REQ-019/REQ-020.

Verification
REQ-037 Reset, then req_valid=4'b1111 with all addresses in bank 0, held 8 cycles -> grants in order 0,1,2,3,0,1,2,3; rsp_valid for each arrives 3 cycles after its grant (RD_LATENCY=2).
REQ-038 Requester 0 reads bank 0 at 0x00100 while requester 2 reads bank 1 at 0x10200 in the same cycle -> both granted; bank_rd_addr = 0x0100 / 0x0200; both rsp_valid fire 3 cycles later with their respective bank data.
REQ-039 clk_en low for 2 cycles while reads are in flight -> no new grants; tags hold; responses are delayed by exactly 2 cycles and data is not corrupted.
REQ-040 reset_n asserted 1 cycle after a grant -> no rsp_valid in the following 4 cycles after release; all outputs are 0 during reset.
REQ-041 With GLB_RDRQ_ARB_PROC_PRIORITY_EN defined, requesters 0 and 1 continuously valid on bank 0 -> requester 0 is granted every cycle and requester 1 never; drop requester 0 -> requester 1 is granted the next cycle.
REQ-042 Requester 3 with address bit 16 = 1 and NUM_BANKS=1 -> req_ready[3] stays 0 for 10 cycles and no bank_rd_en pulse occurs.
